// File: rtl/maj_bist_pkg.sv
// rtl/maj_bist_pkg.sv - shared types and helpers for the majority-gate self-test engine
package maj_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Widest supported vector; narrower vectors are zero-extended before counting.
    localparam int MAX_N = 24;

    // Bits needed to hold a popcount of an n-bit vector without overflow.
    function automatic int CNT_W(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [4:0] popcount(input logic [MAX_N-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < MAX_N; i++) begin
            c = c + {4'b0000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/maj_bist_if.sv
// rtl/maj_bist_if.sv - control, stimulus and result bundle between the self-test engine and its environment
// master: the self-test engine (drives x and the result signals, receives start and y_dut)
// slave : the environment / gate under test (drives start and y_dut, observes the rest)
interface maj_bist_if #(
    parameter int N     = 21,
    parameter int ERR_W = 16
);
    logic             start;
    logic [N-1:0]     x;
    logic             y_dut;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [N-1:0]     first_fail;

    modport master (
        input  start, y_dut,
        output x, busy, done, pass, err_count, first_fail
    );

    modport slave (
        output start, y_dut,
        input  x, busy, done, pass, err_count, first_fail
    );
endinterface

// File: rtl/maj_ref.sv
// rtl/maj_ref.sv - combinational popcount-threshold reference (golden majority)
// x : input vector, N bits
// y : 1 when popcount(x) >= THRESH
module maj_ref
    import maj_bist_pkg::*;
#(
    parameter int N      = 21,
    parameter int THRESH = 11
) (
    input  logic [N-1:0] x,
    output logic         y
);
    localparam int CW = CNT_W(N);

    logic [CW-1:0] cnt;

    assign cnt = CW'(popcount(MAX_N'(x)));
    assign y   = (int'(cnt) >= THRESH);
endmodule

// File: rtl/maj_bist.sv
// rtl/maj_bist.sv - exhaustive sweep engine comparing an N-input majority gate against a reference
// clk, rst : clock, synchronous active-high reset
// bus      : maj_bist_if master - start in, x out, y_dut in, busy/done/pass/err_count/first_fail out
module maj_bist
    import maj_bist_pkg::*;
#(
    parameter int N       = 21,
    parameter int THRESH  = 11,
    parameter int DUT_LAT = 0,
    parameter int ERR_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    maj_bist_if.master bus
);
    localparam int DW = $clog2(DUT_LAT + 2);

    state_t           state;
    logic [N-1:0]     x_q;
    logic             busy_q;
    logic             done_q;
    logic [ERR_W-1:0] err_q;
    logic [N-1:0]     ff_q;
    logic             fail_seen;
    logic [DW-1:0]    drain_cnt;

    logic             ref_now;
    logic             src_valid;
    logic             cmp_valid;
    logic             cmp_ref;
    logic [N-1:0]     cmp_x;

    maj_ref #(.N(N), .THRESH(THRESH)) u_ref (
        .x (x_q),
        .y (ref_now)
    );

    // Only vectors issued in RUN are compared; the held vector in DRAIN is not.
    assign src_valid = (state == ST_RUN);

    // Delay the reference, its vector and a valid tag so each comparison lines up
    // with the vector the gate actually answered for.
    generate
        if (DUT_LAT == 0) begin : g_nodly
            assign cmp_valid = src_valid;
            assign cmp_ref   = ref_now;
            assign cmp_x     = x_q;
        end else begin : g_dly
            logic [DUT_LAT-1:0] v_sr;
            logic [DUT_LAT-1:0] r_sr;
            logic [N-1:0]       x_sr [DUT_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_sr <= '0;
                end else begin
                    v_sr[0] <= src_valid;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        v_sr[i] <= v_sr[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                r_sr[0] <= ref_now;
                x_sr[0] <= x_q;
                for (int i = 1; i < DUT_LAT; i++) begin
                    r_sr[i] <= r_sr[i-1];
                    x_sr[i] <= x_sr[i-1];
                end
            end

            assign cmp_valid = v_sr[DUT_LAT-1];
            assign cmp_ref   = r_sr[DUT_LAT-1];
            assign cmp_x     = x_sr[DUT_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            x_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= '0;
            ff_q      <= '0;
            fail_seen <= 1'b0;
            drain_cnt <= '0;
        end else begin
            if (cmp_valid && (bus.y_dut != cmp_ref)) begin
                if (err_q != '1) begin
                    err_q <= err_q + 1'b1;
                end
                if (!fail_seen) begin
                    ff_q      <= cmp_x;
                    fail_seen <= 1'b1;
                end
            end

            // Result clearing on an accepted start is placed after the compare so it wins;
            // no compare is pending in IDLE/DONE since the delay line has drained by then.
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state     <= ST_RUN;
                        x_q       <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        err_q     <= '0;
                        ff_q      <= '0;
                        fail_seen <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (&x_q) begin
                        if (DUT_LAT > 0) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            state  <= ST_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end else begin
                        x_q <= x_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DW'(DUT_LAT - 1)) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.x          = x_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = done_q && (err_q == '0);
    assign bus.err_count  = err_q;
    assign bus.first_fail = ff_q;
endmodule
